byte_word_packer: RTL and testbench

Downstream consumer of the registered 8-bit byte stream. It packs consecutive bytes into LANES-wide words and presents them on a valid/ready output. A partial word is emitted on an explicit flush or after an idle timeout, with a lane-keep mask. It sits between the byte register stage and the wide datapath (MUL_WIDTH side).

---
 rtl/byte_word_packer_pkg.sv | 20 ++
 rtl/byte_word_packer_pack_idle_timer.sv | 38 +++
 rtl/byte_word_packer.sv | 124 ++++++++++++
 tb/tb_byte_word_packer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/byte_word_packer_pkg.sv
// rtl/byte_word_packer_pkg.sv - shared state enum and width helpers for the byte-to-word packer
package byte_word_packer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } pack_state_t;

  // Lane counter must hold 0..LANES inclusive.
  function automatic int cnt_width(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  // Idle counter must hold 0..TIMEOUT; never narrower than one bit.
  function automatic int idle_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/byte_word_packer_pack_idle_timer.sv
// rtl/byte_word_packer_pack_idle_timer.sv - idle counter that pulses when a partial word has waited too long
module pack_idle_timer
  import byte_word_packer_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int IW = idle_width(TIMEOUT);

  generate
    if (TIMEOUT == 0) begin : g_off
      assign expire = 1'b0;
    end else begin : g_on
      logic [IW-1:0] count;

      // Count idle cycles; clear has priority so an accept or emit restarts the wait.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          count <= '0;
        end else if (clr) begin
          count <= '0;
        end else if (en) begin
          count <= count + IW'(1);
        end
      end

      // Pulse in the cycle whose edge brings the count up to TIMEOUT.
      assign expire = en && !clr && (count == IW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - packs a byte stream into LANES-wide words with flush and idle timeout
module byte_word_packer
  import byte_word_packer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LANES     = 2,
  parameter int OUT_WIDTH = WIDTH * LANES,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [LANES-1:0]     out_keep
);

  localparam int CW = cnt_width(LANES);

  pack_state_t          state, state_n;
  logic [CW-1:0]        cnt, cnt_n, lane_sel;
  logic                 flush_pend, flush_pend_n;
  logic [WIDTH-1:0]     acc [LANES];
  logic                 pending, emit, accept;
  logic                 idle_en, idle_clr, expire;
  logic [LANES-1:0]     keep_n;
  logic [OUT_WIDTH-1:0] data_n;

  // Handshake: a word leaves when one is pending and the output register is free or draining.
  always_comb begin
    pending  = (state == FULL);
    emit     = pending && (!out_valid || out_ready);
    in_ready = (cnt < CW'(LANES)) || emit;
    accept   = in_valid && in_ready;
    lane_sel = emit ? '0 : cnt;
    idle_en  = (cnt != '0) && !accept && !flush_pend;
    idle_clr = accept || emit;
  end

  // Next lane count, flush request and state; a flush only sticks when there is a byte to send.
  always_comb begin
    cnt_n        = cnt;
    flush_pend_n = flush_pend;
    state_n      = state;
    if (emit) begin
      cnt_n        = accept ? CW'(1) : '0;
      flush_pend_n = flush && accept;
    end else begin
      if (accept) cnt_n = cnt + CW'(1);
      if ((flush && ((cnt != '0) || accept)) || expire) flush_pend_n = 1'b1;
    end
    if (cnt_n == '0) begin
      state_n = IDLE;
    end else if ((cnt_n == CW'(LANES)) || flush_pend_n) begin
      state_n = FULL;
    end else begin
      state_n = FILL;
    end
  end

  // Outgoing word image: filled lanes from the accumulator, unfilled lanes forced to zero.
  always_comb begin
    keep_n = '0;
    data_n = '0;
    for (int i = 0; i < LANES; i++) begin
      keep_n[i] = (CW'(i) < cnt);
      if (keep_n[i]) data_n[i*WIDTH +: WIDTH] = acc[i];
    end
  end

  // State, lane counter and flush request registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      flush_pend <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      flush_pend <= flush_pend_n;
    end
  end

  // Accumulator: the accepted byte lands in lane cnt, or lane 0 when a word leaves this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (accept && (lane_sel == CW'(i))) acc[i] <= in_data;
      end
    end
  end

  // Output register: load on emit, drop valid once taken, otherwise hold stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_data  <= data_n;
      out_keep  <= keep_n;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  pack_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (idle_clr),
    .en    (idle_en),
    .expire(expire)
  );

endmodule

// File: tb/tb_byte_word_packer.sv
// tb/tb_byte_word_packer.sv - self-checking bench for byte_word_packer (LANES=2, TIMEOUT=4)
module tb_byte_word_packer;

  localparam int W  = 8;
  localparam int L  = 2;
  localparam int TO = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic           flush = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W*L-1:0] out_data;
  logic [L-1:0]   out_keep;

  int total = 0;
  int bad   = 0;

  byte_word_packer #(
    .WIDTH(W),
    .LANES(L),
    .OUT_WIDTH(W*L),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_keep (out_keep)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit             v;
    logic [W-1:0]   d;
    bit             f;
    bit             r;
    bit             e_ir;
    bit             e_ov;
    logic [W*L-1:0] e_data;
    logic [L-1:0]   e_keep;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: inputs change just after the rising edge, outputs are sampled at the falling edge.
  task automatic step(input bit v, input logic [W-1:0] d, input bit f, input bit r);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Reference model state: bytes of the word being built, the held output word, flags.
  logic [W-1:0]   cur[$];
  logic [W*L-1:0] m_data;
  logic [L-1:0]   m_keep;
  bit             m_ov, m_fp;
  int             m_idle;

  initial begin
    bit m_pend, m_emit, m_ir, m_acc, m_hit;
    int pv;

    // Reset with random inputs toggling.
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom);
      in_data   = W'($urandom);
      flush     = 1'($urandom);
      out_ready = 1'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_out_keep",  32'(out_keep),  32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // Streaming with out_ready held high.
    tbl.push_back('{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00});
    tbl.push_back('{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00});
    tbl.push_back('{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00});
    tbl.push_back('{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 16'h2211, 2'b11});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 16'h4433, 2'b11});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00});
    // Backpressure: 0x2211 held, 0x33/0x44 fill the accumulator, 0x55 waits.
    tbl.push_back('{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00});
    tbl.push_back('{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00});
    tbl.push_back('{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00});
    tbl.push_back('{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 1'b1, 16'h2211, 2'b11});
    tbl.push_back('{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2211, 2'b11});
    tbl.push_back('{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 16'h2211, 2'b11});
    tbl.push_back('{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1, 16'h2211, 2'b11});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 16'h4433, 2'b11});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0055, 2'b01});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00});
    // Flush: partial word, ignored empty flush, flush coincident with a byte.
    tbl.push_back('{1'b1, 8'hAB, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00AB, 2'b01});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00});
    tbl.push_back('{1'b1, 8'hCD, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00CD, 2'b01});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00});

    foreach (tbl[k]) begin
      step(tbl[k].v, tbl[k].d, tbl[k].f, tbl[k].r);
      chk($sformatf("tbl%0d_in_ready", k), 32'(in_ready), 32'(tbl[k].e_ir));
      chk($sformatf("tbl%0d_out_valid", k), 32'(out_valid), 32'(tbl[k].e_ov));
      if (tbl[k].e_ov) begin
        chk($sformatf("tbl%0d_out_data", k), 32'(out_data), 32'(tbl[k].e_data));
        chk($sformatf("tbl%0d_out_keep", k), 32'(out_keep), 32'(tbl[k].e_keep));
      end
    end

    // Timeout: lone byte comes out TIMEOUT+1 cycles after its accept.
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    for (int k = 1; k <= TO + 1; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk($sformatf("to_wait%0d", k), 32'(out_valid), 32'd0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("to_out_valid", 32'(out_valid), 32'd1);
    chk("to_out_data",  32'(out_data),  32'h005A);
    chk("to_out_keep",  32'(out_keep),  32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Timeout pre-empted: second byte on idle cycle 3 completes the word instead.
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("to2_wait1", 32'(out_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("to2_wait2", 32'(out_valid), 32'd0);
    step(1'b1, 8'h3C, 1'b0, 1'b1);
    chk("to2_in_ready", 32'(in_ready), 32'd1);
    chk("to2_wait3", 32'(out_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("to2_wait4", 32'(out_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("to2_out_valid", 32'(out_valid), 32'd1);
    chk("to2_out_data",  32'(out_data),  32'h3C5A);
    chk("to2_out_keep",  32'(out_keep),  32'h3);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk($sformatf("to2_quiet%0d", k), 32'(out_valid), 32'd0);
    end

    // Reset mid-operation: held word and partial byte are discarded.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("mid_held_valid", 32'(out_valid), 32'd1);
    chk("mid_held_data",  32'(out_data),  32'h2211);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data",  32'(out_data),  32'd0);
    chk("mid_rst_keep",  32'(out_keep),  32'd0);
    chk("mid_rst_ready", 32'(in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 8'h77, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("mid_post_wait", 32'(out_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("mid_post_valid", 32'(out_valid), 32'd1);
    chk("mid_post_data",  32'(out_data),  32'h0077);
    chk("mid_post_keep",  32'(out_keep),  32'h1);

    // Random traffic against the queue-based model.
    do_reset();
    cur.delete();
    m_data = '0; m_keep = '0; m_ov = 1'b0; m_fp = 1'b0; m_idle = 0;
    pv = 70;
    for (int c = 0; c < 3000; c++) begin
      if ((c % 64) == 0) begin
        case ($urandom_range(0, 2))
          0: pv = 95;
          1: pv = 50;
          default: pv = 8;
        endcase
      end
      step(($urandom_range(0, 99) < pv), W'($urandom), ($urandom_range(0, 11) == 0),
           ($urandom_range(0, 99) < 65));
      m_pend = (cur.size() == L) || (m_fp && (cur.size() > 0));
      m_emit = m_pend && (!m_ov || out_ready);
      m_ir   = (cur.size() < L) || m_emit;
      chk("rnd_in_ready", 32'(in_ready), 32'(m_ir));
      chk("rnd_out_valid", 32'(out_valid), 32'(m_ov));
      if (m_ov) begin
        chk("rnd_out_data", 32'(out_data), 32'(m_data));
        chk("rnd_out_keep", 32'(out_keep), 32'(m_keep));
      end
      m_acc = in_valid && m_ir;
      m_hit = 1'b0;
      if (m_acc || m_emit) begin
        m_idle = 0;
      end else if ((cur.size() > 0) && !m_fp) begin
        m_idle++;
        if (m_idle == TO) m_hit = 1'b1;
      end
      if (m_emit) begin
        m_data = '0;
        m_keep = '0;
        foreach (cur[i]) begin
          m_data = m_data | ((W*L)'(cur[i]) << (W * i));
          m_keep[i] = 1'b1;
        end
        m_ov = 1'b1;
        cur.delete();
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (m_acc) cur.push_back(in_data);
      if (m_emit) m_fp = flush && m_acc;
      else        m_fp = m_fp || (flush && (cur.size() > 0)) || m_hit;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
